mvm_host_sequencer: RTL and testbench

//  Host-side partner of the matrix-vector multiplier: gathers a 4x4 matrix + 4-vector from an

---
 rtl/mvm_host_sequencer_if.sv | 33 +++
 rtl/mvm_host_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mvm_host_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_host_sequencer_if.sv
// Bundle of every stream and multiplier-side signal of the host sequencer.
// Handshake rule for both streams (in_* and out_*): a transfer happens on a
// rising clock edge where valid and ready are both high; the source holds data
// and valid stable until that edge, and ready may change freely while valid is low.
interface mvm_host_sequencer_if #(
   parameter int DW = 8,
   parameter int OW = 16
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic          out_ready;
   logic          mvm_start;
   logic [DW-1:0] mvm_data_in;
   logic [OW-1:0] mvm_data_out;
   logic          mvm_done;
   logic          busy;
   logic          err_timeout;

   // Sequencer side.
   modport slave (
      input  in_valid, in_data, out_ready, mvm_data_out, mvm_done,
      output in_ready, out_valid, out_data, mvm_start, mvm_data_in, busy, err_timeout
   );

   // System bus plus multiplier side.
   modport master (
      output in_valid, in_data, out_ready, mvm_data_out, mvm_done,
      input  in_ready, out_valid, out_data, mvm_start, mvm_data_in, busy, err_timeout
   );
endinterface

// File: rtl/mvm_host_sequencer.sv
// Host sequencer for the matrix-vector multiplier: buffers one frame
// (matrix row-major, then vector), streams it gap-free to the multiplier,
// collects the results after done and replays them on the output stream.
module mvm_host_sequencer #(
   parameter int DW      = 8,
   parameter int OW      = 16,
   parameter int M_ELEMS = 16,
   parameter int X_ELEMS = 4,
   parameter int Y_ELEMS = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   mvm_host_sequencer_if.slave  bus,
   output logic [2:0]           dbg_state
);
   localparam int N  = M_ELEMS + X_ELEMS;
   localparam int IW = $clog2(N + 1);
   localparam int YW = (Y_ELEMS > 1) ? $clog2(Y_ELEMS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] N_FULL = IW'(N);
   localparam logic [IW-1:0] N_LAST = IW'(N - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_ELEMS - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_FEED  = 3'd2,
      S_WAIT  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t        state, state_next;
   logic [DW-1:0] buf_q [N];
   logic [OW-1:0] y_q [Y_ELEMS];
   logic [IW-1:0] wr_idx, rd_idx;
   logic [TW-1:0] tmo;
   logic [YW-1:0] cap_idx, out_idx;
   logic          cap_active;
   logic          err_q;
   logic          in_ready_int;
   logic          accept;
   logic          frame_full;

   // A frame counts as complete if it already is, or the 20th element lands this cycle.
   assign accept     = bus.in_valid & in_ready_int;
   assign frame_full = (wr_idx == N_FULL) || (accept && (wr_idx == N_LAST));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state decode; a frame filled during DRAIN is started only once DRAIN ends.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (frame_full) state_next = S_START;
         S_START: state_next = S_FEED;
         S_FEED:  if (rd_idx == N_LAST) state_next = S_WAIT;
         S_WAIT: begin
            if (cap_active) begin
               if (cap_idx == Y_LAST) state_next = S_DRAIN;
            end else if (!bus.mvm_done && (tmo == T_LAST)) begin
               state_next = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (bus.out_ready && (out_idx == Y_LAST))
               state_next = frame_full ? S_START : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state; in_ready is forced low while reset is held.
   always_comb begin
      in_ready_int    = 1'b0;
      bus.mvm_start   = 1'b0;
      bus.mvm_data_in = '0;
      bus.out_valid   = 1'b0;
      bus.out_data    = '0;
      bus.busy        = 1'b0;
      case (state)
         S_IDLE:  in_ready_int = (wr_idx < N_FULL);
         S_START: begin
            bus.mvm_start = 1'b1;
            bus.busy      = 1'b1;
         end
         S_FEED: begin
            bus.mvm_data_in = buf_q[rd_idx];
            bus.busy        = 1'b1;
         end
         S_WAIT:  bus.busy = 1'b1;
         S_DRAIN: begin
            in_ready_int  = (wr_idx < N_FULL);
            bus.out_valid = 1'b1;
            bus.out_data  = y_q[out_idx];
         end
         default: ;
      endcase
      if (reset) in_ready_int = 1'b0;
   end

   assign bus.in_ready    = in_ready_int;
   assign bus.err_timeout = err_q;
   assign dbg_state       = state;

   // Datapath: input buffer, feed pointer, timeout, result capture and drain pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) buf_q[i] <= '0;
         for (int k = 0; k < Y_ELEMS; k++) y_q[k] <= '0;
         wr_idx     <= '0;
         rd_idx     <= '0;
         tmo        <= '0;
         cap_idx    <= '0;
         out_idx    <= '0;
         cap_active <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            buf_q[wr_idx] <= bus.in_data;
            wr_idx        <= wr_idx + 1'b1;
         end

         if (state == S_FEED) begin
            if (rd_idx == N_LAST) begin
               rd_idx <= '0;
               wr_idx <= '0;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end

         if (state == S_WAIT) begin
            if (cap_active) begin
               y_q[cap_idx] <= bus.mvm_data_out;
               if (cap_idx == Y_LAST) begin
                  cap_active <= 1'b0;
                  cap_idx    <= '0;
               end else begin
                  cap_idx <= cap_idx + 1'b1;
               end
            end else if (bus.mvm_done) begin
               y_q[0]     <= bus.mvm_data_out;
               cap_active <= 1'b1;
               cap_idx    <= YW'(1);
               tmo        <= '0;
            end else if (tmo == T_LAST) begin
               err_q <= 1'b1;
               tmo   <= '0;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end else begin
            tmo <= '0;
         end

         if ((state == S_DRAIN) && bus.out_ready)
            out_idx <= (out_idx == Y_LAST) ? '0 : out_idx + 1'b1;
      end
   end
endmodule

// File: tb/tb_mvm_host_sequencer.sv
// Directed bench for mvm_host_sequencer with a behavioural multiplier model.
module tb_mvm_host_sequencer;
   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0]  frame [20];
   logic [15:0] exp_q [$];
   bit          mdl_done_en = 1'b1;
   int          mdl_lat     = 1;

   mvm_host_sequencer_if #(.DW(8), .OW(16)) bus ();

   mvm_host_sequencer #(
      .DW(8), .OW(16), .M_ELEMS(16), .X_ELEMS(4), .Y_ELEMS(4), .TIMEOUT(64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Multiplier model: checks the element stream after start, then returns
   // y = A*x as a one-cycle done with y[0] followed by y[1..3].
   initial begin
      logic [7:0]         fed [20];
      logic signed [15:0] y [4];
      logic signed [15:0] pa, pb;
      bit                 ok;
      bus.mvm_done     = 1'b0;
      bus.mvm_data_out = '0;
      forever begin
         @(negedge clk);
         if (bus.mvm_start && !reset) begin
            ok = 1'b1;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (reset) begin
                  ok = 1'b0;
                  break;
               end
               fed[i] = bus.mvm_data_in;
               chk($sformatf("feed[%0d]", i), bus.mvm_data_in, frame[i]);
            end
            if (ok && mdl_done_en) begin
               for (int r = 0; r < 4; r++) begin
                  y[r] = '0;
                  for (int c = 0; c < 4; c++) begin
                     pa = 16'($signed(fed[r*4 + c]));
                     pb = 16'($signed(fed[16 + c]));
                     y[r] = y[r] + pa * pb;
                  end
               end
               repeat (mdl_lat) @(negedge clk);
               bus.mvm_done     = 1'b1;
               bus.mvm_data_out = y[0];
               for (int k = 1; k < 4; k++) begin
                  @(negedge clk);
                  bus.mvm_done     = 1'b0;
                  bus.mvm_data_out = y[k];
               end
               @(negedge clk);
               bus.mvm_data_out = '0;
            end
         end
      end
   end

   // Driver: pushes frame[] on the input stream, optionally with idle gaps.
   task automatic send_frame(input bit gaps, input bit exp_start);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      while (i < 20 && guard < 400) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = frame[i];
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc && i == 19) chk("no_early_start", bus.mvm_start, 0);
         @(negedge clk);
         if (acc) i++;
         guard++;
      end
      bus.in_valid = 1'b0;
      chk("elements_accepted", i, 20);
      if (exp_start) begin
         chk("start_after_20th", bus.mvm_start, 1);
         chk("busy_in_start", bus.busy, 1);
      end
   endtask

   // Scoreboard drain: pops four results and compares against exp_q.
   task automatic drain_frame(input bit chk_start);
      int g;
      for (int k = 0; k < 4; k++) begin
         g = 0;
         while (!bus.out_valid && g < 300) begin
            @(negedge clk);
            g++;
         end
         chk("out_valid", bus.out_valid, 1);
         chk($sformatf("out_data[%0d]", k), bus.out_data, exp_q.pop_front());
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      if (chk_start) chk("start_after_pop", bus.mvm_start, 1);
   endtask

   task automatic load_identity(input int x0, input int x1, input int x2, input int x3);
      for (int i = 0; i < 16; i++) frame[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      frame[16] = 8'(x0);
      frame[17] = 8'(x1);
      frame[18] = 8'(x2);
      frame[19] = 8'(x3);
   endtask

   task automatic load_mixed();
      int b [20] = '{1, 2, 3, 4, -1, -1, -1, -1, 0, 0, 0, 10, 5, 0, -5, 0, 10, 20, 30, 40};
      for (int i = 0; i < 20; i++) frame[i] = 8'(b[i]);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"},    bus.in_ready, 0);
      chk({tag, "_out_valid"},   bus.out_valid, 0);
      chk({tag, "_out_data"},    bus.out_data, 0);
      chk({tag, "_mvm_start"},   bus.mvm_start, 0);
      chk({tag, "_mvm_data_in"}, bus.mvm_data_in, 0);
      chk({tag, "_busy"},        bus.busy, 0);
      chk({tag, "_err_timeout"}, bus.err_timeout, 0);
   endtask

   // Main sequence.
   initial begin
      int g;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", bus.in_ready, 1);
      chk("post_reset_state", dbg_state, 0);

      // Identity matrix, x = [1,2,3,4].
      load_identity(1, 2, 3, 4);
      exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0003); exp_q.push_back(16'h0004);
      mdl_lat = 3;
      send_frame(1'b0, 1'b1);
      drain_frame(1'b0);

      // All a = -1, x = 127: every y = -508.
      for (int i = 0; i < 16; i++) frame[i] = 8'hFF;
      for (int i = 16; i < 20; i++) frame[i] = 8'h7F;
      repeat (4) exp_q.push_back(16'hFE04);
      mdl_lat = 1;
      send_frame(1'b0, 1'b1);
      drain_frame(1'b0);

      // Gappy input; y = [300, -100, 400, -100].
      load_mixed();
      exp_q.push_back(16'h012C); exp_q.push_back(16'hFF9C);
      exp_q.push_back(16'h0190); exp_q.push_back(16'hFF9C);
      send_frame(1'b1, 1'b1);
      drain_frame(1'b0);

      // Output back-pressure while the next frame is buffered.
      load_mixed();
      exp_q.push_back(16'h012C); exp_q.push_back(16'hFF9C);
      exp_q.push_back(16'h0190); exp_q.push_back(16'hFF9C);
      send_frame(1'b0, 1'b1);
      g = 0;
      while (!bus.out_valid && g < 300) begin
         @(negedge clk);
         g++;
      end
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_data_first", bus.out_data, 16'h012C);
      repeat (10) @(negedge clk);
      chk("hold_data_10", bus.out_data, 16'h012C);
      load_identity(-1, -2, -3, -4);
      exp_q.push_back(16'hFFFF); exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'hFFFD); exp_q.push_back(16'hFFFC);
      send_frame(1'b0, 1'b0);
      chk("full_in_ready", bus.in_ready, 0);
      chk("held_no_start", bus.mvm_start, 0);
      chk("hold_data_end", bus.out_data, 16'h012C);
      chk("hold_state", dbg_state, 4);
      drain_frame(1'b1);
      drain_frame(1'b0);

      // Multiplier never answers: timeout after 64 WAIT cycles.
      mdl_done_en = 1'b0;
      load_identity(1, 1, 1, 1);
      send_frame(1'b0, 1'b1);
      repeat (21) @(negedge clk);
      chk("wait_entered", dbg_state, 3);
      chk("wait_busy", bus.busy, 1);
      repeat (63) @(negedge clk);
      chk("err_before_timeout", bus.err_timeout, 0);
      chk("state_before_timeout", dbg_state, 3);
      @(negedge clk);
      chk("err_at_timeout", bus.err_timeout, 1);
      chk("idle_after_timeout", dbg_state, 0);
      chk("in_ready_after_timeout", bus.in_ready, 1);
      chk("busy_after_timeout", bus.busy, 0);
      repeat (5) @(negedge clk);
      chk("err_sticky", bus.err_timeout, 1);
      mdl_done_en = 1'b1;

      // Reset in the middle of FEED, then a clean frame.
      load_identity(1, 2, 3, 4);
      send_frame(1'b0, 1'b1);
      repeat (5) @(negedge clk);
      chk("feeding_before_reset", dbg_state, 2);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_all_zero("mid_feed_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0003); exp_q.push_back(16'h0004);
      send_frame(1'b0, 1'b1);
      drain_frame(1'b0);
      chk("exp_q_empty", exp_q.size(), 0);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
